// File: rtl/board_port_arbiter_if.sv
// Board store read-port bundle shared by the requesters, the arbiter and the store.
interface board_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 4
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        rd_en;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_rd;
  logic [DATA_W-1:0]         mem_rdata;
  logic [DATA_W-1:0]         rdata;
  logic [NUM_REQ-1:0]        rvalid;
  logic [NUM_REQ-1:0]        overrun;
  logic                      busy;

  // Requesters plus board store: drive requests and store data, observe the arbiter.
  modport master (
    output req, rd_en, addr, mem_rdata,
    input  gnt, mem_addr, mem_rd, rdata, rvalid, overrun, busy
  );

  // Arbiter side.
  modport slave (
    input  req, rd_en, addr, mem_rdata,
    output gnt, mem_addr, mem_rd, rdata, rvalid, overrun, busy
  );
endinterface

// File: rtl/board_port_arbiter.sv
// Round-robin arbiter for the single read port of the 64-square board store,
// with a hold watchdog that forces a stalled owner off the port.
module board_port_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned HOLD_MAX = 255
) (
  input  logic               clk,
  input  logic               reset,
  board_port_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   owner, owner_nx;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nx;
  logic [CNT_W-1:0]   hold_cnt, hold_cnt_nx;
  logic [CNT_W:0]     hold_inc;
  logic               expire;
  logic [NUM_REQ-1:0] gnt_q, gnt_nx;
  logic [NUM_REQ-1:0] ovr_q, ovr_nx;
  logic [NUM_REQ-1:0] lock, lock_nx;
  logic               busy_q, busy_nx;

  logic [NUM_REQ-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   idx;
  logic               owner_req;

  logic [ADDR_W-1:0]  owner_addr;
  logic [ADDR_W-1:0]  last_addr;
  logic               mem_rd_c;
  logic [NUM_REQ-1:0] rvalid_q;
  logic [DATA_W-1:0]  rdata_q;

  // Round-robin pick: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin
    elig   = bus.req & ~lock;
    found  = 1'b0;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && elig[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Owner's address slice and read strobe; a read needs the owner's grant.
  always_comb begin
    owner_addr = '0;
    mem_rd_c   = 1'b0;
    owner_req  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == IDX_W'(i)) begin
        owner_addr = bus.addr[i*ADDR_W +: ADDR_W];
        mem_rd_c   = bus.rd_en[i] & gnt_q[i];
        owner_req  = bus.req[i] & gnt_q[i];
      end
    end
  end

  // Watchdog: expire on the HOLD cycle whose increment brings hold_cnt to HOLD_MAX.
  always_comb begin
    hold_inc = {1'b0, hold_cnt} + (CNT_W+1)'(1);
    expire   = (hold_inc >= {1'b0, HOLD_LIM});
  end

  // Next-state and next registered outputs.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    rr_ptr_nx   = rr_ptr;
    hold_cnt_nx = hold_cnt;
    gnt_nx      = gnt_q;
    ovr_nx      = '0;
    lock_nx     = lock & bus.req;
    busy_nx     = busy_q;

    unique case (state)
      IDLE, DRAIN: begin
        // DRAIN arbitrates like IDLE so the next grant can follow immediately.
        state_nx = IDLE;
        gnt_nx   = '0;
        if (found) begin
          state_nx    = HOLD;
          owner_nx    = winner;
          gnt_nx      = NUM_REQ'(1) << winner;
          rr_ptr_nx   = (32'(winner) == NUM_REQ - 1) ? '0 : winner + IDX_W'(1);
          hold_cnt_nx = '0;
        end
      end
      HOLD: begin
        hold_cnt_nx = expire ? HOLD_LIM : hold_inc[CNT_W-1:0];
        if (!owner_req) begin
          // Normal release wins over a coincident watchdog expiry.
          state_nx = DRAIN;
          gnt_nx   = '0;
        end else if (expire) begin
          state_nx = DRAIN;
          gnt_nx   = '0;
          ovr_nx   = gnt_q;
          lock_nx  = lock_nx | gnt_q;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '0;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      ovr_q    <= '0;
      lock     <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      rr_ptr   <= rr_ptr_nx;
      hold_cnt <= hold_cnt_nx;
      gnt_q    <= gnt_nx;
      ovr_q    <= ovr_nx;
      lock     <= lock_nx;
      busy_q   <= busy_nx;
    end
  end

  // Read return: store data is captured on the edge closing the issue cycle,
  // tagged with the grant held at issue so a read landing in DRAIN stays correct.
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q  <= '0;
      rdata_q   <= '0;
      last_addr <= '0;
    end else begin
      rvalid_q <= mem_rd_c ? gnt_q : '0;
      if (mem_rd_c) begin
        rdata_q   <= bus.mem_rdata;
        last_addr <= owner_addr;
      end
    end
  end

  assign bus.mem_rd   = mem_rd_c;
  assign bus.mem_addr = mem_rd_c ? owner_addr : last_addr;
  assign bus.gnt      = gnt_q;
  assign bus.overrun  = ovr_q;
  assign bus.busy     = busy_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_board_port_arbiter.sv
// Bench for board_port_arbiter: one instance with the default hold limit for
// grant/read tests, one with HOLD_MAX=10 for the watchdog.
module tb_board_port_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle index seen by both the drivers and the monitor.
  always @(posedge clk) cyc <= cyc + 1;

  board_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  board_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_w ();

  board_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(255))
    u_dut (.clk(clk), .reset(reset), .bus(bus_a));

  board_port_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_MAX(10))
    u_wd (.clk(clk), .reset(reset), .bus(bus_w));

  // Board image: square 12 holds 4'hB.
  function automatic logic [3:0] square(input logic [5:0] a);
    return a[3:0] ^ 4'h7;
  endfunction

  assign bus_a.mem_rdata = square(bus_a.mem_addr);
  assign bus_w.mem_rdata = square(bus_w.mem_addr);

  typedef struct {
    logic [3:0] tag;
    logic [3:0] data;
    int         due;
  } exp_t;

  exp_t q_a[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a read for requester r and record the response expected next cycle.
  task automatic issue(input int r, input logic [5:0] a);
    bus_a.rd_en[r] = 1'b1;
    bus_a.addr[r*ADDR_W +: ADDR_W] = a;
    q_a.push_back('{tag: 4'(1 << r), data: square(a), due: cyc + 1});
  endtask

  // Scoreboard monitor: every rvalid must match the oldest pending read on its due cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_a.size() != 0 && q_a[0].due == cyc) begin
        e = q_a.pop_front();
        check("sb_rvalid", 32'(bus_a.rvalid), 32'(e.tag));
        check("sb_rdata", 32'(bus_a.rdata), 32'(e.data));
      end else if (bus_a.rvalid != '0) begin
        check("sb_spurious_rvalid", 32'(bus_a.rvalid), 32'(0));
      end
      if (bus_w.rvalid != '0) check("wd_spurious_rvalid", 32'(bus_w.rvalid), 32'(0));
    end
  endtask

  initial begin
    int own;
    bus_a.req = '0; bus_a.rd_en = '0; bus_a.addr = '0;
    bus_w.req = '0; bus_w.rd_en = '0; bus_w.addr = '0;
    reset = 1'b1;
    fork
      monitor();
    join_none
    repeat (2) tick();

    // Reset values.
    check("rst_gnt", 32'(bus_a.gnt), 32'(0));
    check("rst_rvalid", 32'(bus_a.rvalid), 32'(0));
    check("rst_overrun", 32'(bus_a.overrun), 32'(0));
    check("rst_rdata", 32'(bus_a.rdata), 32'(0));
    check("rst_busy", 32'(bus_a.busy), 32'(0));
    check("rst_mem_rd", 32'(bus_a.mem_rd), 32'(0));
    check("rst_mem_addr", 32'(bus_a.mem_addr), 32'(0));
    check("rst_wd_gnt", 32'(bus_w.gnt), 32'(0));
    reset = 1'b0;

    // Single requester, one read of square 12.
    bus_a.req = 4'b0100;
    tick();
    check("single_gnt", 32'(bus_a.gnt), 32'(4'b0100));
    check("single_busy", 32'(bus_a.busy), 32'(1));
    issue(2, 6'd12);
    #1;
    check("single_mem_rd", 32'(bus_a.mem_rd), 32'(1));
    check("single_mem_addr", 32'(bus_a.mem_addr), 32'(12));
    tick();
    check("single_rdata", 32'(bus_a.rdata), 32'(4'hB));
    check("single_rvalid", 32'(bus_a.rvalid), 32'(4'b0100));
    bus_a.rd_en = '0;
    bus_a.req   = '0;
    #1;
    check("single_idle_mem_rd", 32'(bus_a.mem_rd), 32'(0));
    check("single_addr_hold", 32'(bus_a.mem_addr), 32'(12));
    tick();
    check("single_drain_gnt", 32'(bus_a.gnt), 32'(0));
    check("single_drain_busy", 32'(bus_a.busy), 32'(1));
    tick();
    check("single_idle_busy", 32'(bus_a.busy), 32'(0));

    // Round-robin from a fresh reset: owners 0,1,2,3,0, each holding 3 cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus_a.req = 4'hF;
    tick();
    for (int g = 0; g < 5; g++) begin
      own = g % 4;
      for (int h = 0; h < 3; h++) begin
        check("rr_gnt", 32'(bus_a.gnt), 32'(1) << own);
        if (h == 2) bus_a.req[own] = 1'b0;
        tick();
      end
      check("rr_drain_gnt", 32'(bus_a.gnt), 32'(0));
      check("rr_drain_busy", 32'(bus_a.busy), 32'(1));
      bus_a.req[own] = 1'b1;
      tick();
    end
    bus_a.req = '0;
    repeat (2) tick();
    check("rr_end_busy", 32'(bus_a.busy), 32'(0));

    // Burst of 64 back-to-back reads; the last one coincides with the req drop.
    bus_a.req = 4'b1000;
    tick();
    check("burst_gnt", 32'(bus_a.gnt), 32'(4'b1000));
    for (int a = 0; a < 64; a++) begin
      issue(3, 6'(a));
      if (a == 63) bus_a.req = '0;
      tick();
    end
    bus_a.rd_en = '0;
    check("burst_drain_gnt", 32'(bus_a.gnt), 32'(0));
    check("burst_last_rvalid", 32'(bus_a.rvalid), 32'(4'b1000));
    tick();
    check("burst_idle_busy", 32'(bus_a.busy), 32'(0));

    // Non-owner read strobe is ignored.
    bus_a.req = 4'b0001;
    tick();
    check("iso_gnt", 32'(bus_a.gnt), 32'(4'b0001));
    bus_a.rd_en = 4'b0100;
    bus_a.addr[2*ADDR_W +: ADDR_W] = 6'd5;
    #1;
    check("iso_mem_rd", 32'(bus_a.mem_rd), 32'(0));
    check("iso_mem_addr", 32'(bus_a.mem_addr), 32'(63));
    tick();
    check("iso_rvalid", 32'(bus_a.rvalid), 32'(0));

    // Reset while a read is in flight: no rvalid, pointer back to 0.
    bus_a.rd_en = 4'b0001;
    bus_a.addr[0 +: ADDR_W] = 6'd7;
    reset = 1'b1;
    #1;
    check("rst_inflight_mem_rd", 32'(bus_a.mem_rd), 32'(1));
    tick();
    check("rst_mid_gnt", 32'(bus_a.gnt), 32'(0));
    check("rst_mid_rvalid", 32'(bus_a.rvalid), 32'(0));
    check("rst_mid_busy", 32'(bus_a.busy), 32'(0));
    reset = 1'b0;
    bus_a.rd_en = '0;
    bus_a.req = 4'hF;
    tick();
    check("rst_rr_ptr_gnt", 32'(bus_a.gnt), 32'(4'b0001));
    bus_a.req = '0;
    repeat (3) tick();
    check("rst_end_busy", 32'(bus_a.busy), 32'(0));

    // Watchdog: owner 1 holds forever, forced off after 10 HOLD cycles.
    bus_w.req = 4'b0010;
    tick();
    for (int h = 0; h < 10; h++) begin
      check("wd_hold_gnt", 32'(bus_w.gnt), 32'(4'b0010));
      check("wd_hold_ovr", 32'(bus_w.overrun), 32'(0));
      tick();
    end
    check("wd_overrun", 32'(bus_w.overrun), 32'(4'b0010));
    check("wd_drop_gnt", 32'(bus_w.gnt), 32'(0));
    bus_w.req = 4'b0011;
    tick();
    check("wd_next_gnt", 32'(bus_w.gnt), 32'(4'b0001));
    check("wd_ovr_pulse", 32'(bus_w.overrun), 32'(0));
    bus_w.req[0] = 1'b0;
    tick();
    check("wd_drain2_gnt", 32'(bus_w.gnt), 32'(0));
    tick();
    check("wd_lockout_gnt", 32'(bus_w.gnt), 32'(0));
    check("wd_lockout_busy", 32'(bus_w.busy), 32'(0));
    bus_w.req[1] = 1'b0;
    tick();
    check("wd_lowreq_gnt", 32'(bus_w.gnt), 32'(0));
    bus_w.req[1] = 1'b1;
    tick();
    check("wd_regrant", 32'(bus_w.gnt), 32'(4'b0010));

    // Req drops on the very HOLD cycle the watchdog would expire.
    for (int h = 0; h < 9; h++) begin
      check("edge_hold_gnt", 32'(bus_w.gnt), 32'(4'b0010));
      tick();
    end
    check("edge_last_gnt", 32'(bus_w.gnt), 32'(4'b0010));
    bus_w.req[1] = 1'b0;
    tick();
    check("edge_no_overrun", 32'(bus_w.overrun), 32'(0));
    check("edge_drain_gnt", 32'(bus_w.gnt), 32'(0));
    bus_w.req[1] = 1'b1;
    tick();
    check("edge_no_lockout", 32'(bus_w.gnt), 32'(4'b0010));
    bus_w.req = '0;
    repeat (3) tick();
    check("edge_end_busy", 32'(bus_w.busy), 32'(0));

    repeat (2) tick();
    check("sb_pending", 32'(q_a.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
